// File: rtl/vector_pe_pkg.sv
// vector_pe_pkg: default widths, lane data types and accumulator saturation limits for the vector PE
package vector_pe_pkg;
    localparam int DATA_W      = 8;
    localparam int ACC_W       = 32;
    localparam int LANES_N     = 4;
    localparam int MULT_PIPE_D = 1;
    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]  psum_t;
    localparam psum_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam psum_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
endpackage

// File: rtl/vector_pe_lane.sv
// vector_pe_lane: one MAC lane (shadow/active weight, multiply, optional product stage, add/clamp); VECTOR_PE_SATURATE_EN selects saturation
module vector_pe_lane
    import vector_pe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ACC_WIDTH  = ACC_W,
    parameter int MULT_PIPE  = MULT_PIPE_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sync_rst,
    input  logic                  en,
    input  logic                  load,
    input  logic                  swap,
    input  logic                  in_valid,
    input  logic                  s1_valid,
    input  logic [DATA_WIDTH-1:0] weight_in,
    input  logic [DATA_WIDTH-1:0] act_in,
    input  logic [ACC_WIDTH-1:0]  psum_in,
    output logic [ACC_WIDTH-1:0]  psum_out,
    output logic                  ovf
);
    localparam int PW = 2 * DATA_WIDTH;
    logic signed [DATA_WIDTH-1:0] shadow_q, shadow_d, active_q, active_d;
    logic signed [PW-1:0]         prod, prod_q, prod_d, add_prod;
    logic signed [ACC_WIDTH-1:0]  psum1_q, psum1_d, add_psum, sum, psum_q, psum_d;
    logic                         add_valid, clamp, ovf_q, ovf_d;
`ifdef VECTOR_PE_SATURATE_EN
    logic signed [ACC_WIDTH:0]    sum_w;
`endif

    always_comb begin
        prod      = $signed(act_in) * active_q;
        add_prod  = (MULT_PIPE != 0) ? prod_q : prod;
        add_psum  = (MULT_PIPE != 0) ? psum1_q : $signed(psum_in);
        add_valid = (MULT_PIPE != 0) ? s1_valid : in_valid;
`ifdef VECTOR_PE_SATURATE_EN
        sum_w = (ACC_WIDTH+1)'(add_prod) + (ACC_WIDTH+1)'(add_psum);
        clamp = sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1];
        // the extra sign bit picks which rail to clamp to
        sum   = clamp ? {sum_w[ACC_WIDTH], {(ACC_WIDTH-1){~sum_w[ACC_WIDTH]}}} : sum_w[ACC_WIDTH-1:0];
`else
        clamp = 1'b0;
        sum   = ACC_WIDTH'(add_prod) + add_psum;
`endif
        shadow_d = shadow_q;
        active_d = active_q;
        prod_d   = prod_q;
        psum1_d  = psum1_q;
        psum_d   = psum_q;
        ovf_d    = ovf_q;
        if (sync_rst) begin
            shadow_d = '0;
            active_d = '0;
            prod_d   = '0;
            psum1_d  = '0;
            psum_d   = '0;
            ovf_d    = 1'b0;
        end else if (en) begin
            shadow_d = load ? weight_in : shadow_q;
            active_d = swap ? shadow_q : active_q;
            prod_d   = in_valid ? prod : prod_q;
            psum1_d  = in_valid ? psum_in : psum1_q;
            psum_d   = add_valid ? sum : psum_q;
            ovf_d    = ovf_q | (add_valid & clamp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            prod_q   <= '0;
            psum1_q  <= '0;
            psum_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            prod_q   <= prod_d;
            psum1_q  <= psum1_d;
            psum_q   <= psum_d;
            ovf_q    <= ovf_d;
        end
    end

    assign psum_out = psum_q;
    assign ovf      = ovf_q;
endmodule

// File: rtl/vector_processing_element.sv
// vector_processing_element: LANES-wide weight-stationary MAC tile with double-buffered weights; define VECTOR_PE_SATURATE_EN for saturating accumulation
module vector_processing_element
    import vector_pe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ACC_WIDTH  = ACC_W,
    parameter int LANES      = LANES_N,
    parameter int MULT_PIPE  = MULT_PIPE_D
) (
    input  logic                        CLK,
    input  logic                        ASYNC_RST,
    input  logic                        SYNC_RST,
    input  logic                        EN,
    input  logic                        InValid,
    input  logic [LANES*DATA_WIDTH-1:0] Input,
    input  logic [LANES*ACC_WIDTH-1:0]  PsumIn,
    input  logic                        WeightLoad,
    input  logic [LANES*DATA_WIDTH-1:0] WeightIn,
    input  logic                        WeightSwap,
    output logic                        WeightReady,
    output logic [LANES*DATA_WIDTH-1:0] ToRight,
    output logic                        ToRightValid,
    output logic [LANES*ACC_WIDTH-1:0]  PsumOut,
    output logic                        PsumValid,
    output logic [LANES-1:0]            Overflow
);
    logic                        ready_q, ready_d, trv_q, trv_d, v1_q, v1_d, pv_q, pv_d, swap_fire;
    logic [LANES*DATA_WIDTH-1:0] tr_q, tr_d;

    assign swap_fire = WeightSwap & ready_q;

    always_comb begin
        ready_d = ready_q;
        tr_d    = tr_q;
        trv_d   = trv_q;
        v1_d    = v1_q;
        pv_d    = pv_q;
        if (SYNC_RST) begin
            ready_d = 1'b0;
            tr_d    = '0;
            trv_d   = 1'b0;
            v1_d    = 1'b0;
            pv_d    = 1'b0;
        end else if (EN) begin
            // a load always leaves fresh weights pending, even if a swap consumed the old ones
            ready_d = WeightLoad | (ready_q & ~WeightSwap);
            tr_d    = InValid ? Input : tr_q;
            trv_d   = InValid;
            v1_d    = InValid;
            pv_d    = (MULT_PIPE != 0) ? v1_q : InValid;
        end
    end

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            ready_q <= 1'b0;
            tr_q    <= '0;
            trv_q   <= 1'b0;
            v1_q    <= 1'b0;
            pv_q    <= 1'b0;
        end else begin
            ready_q <= ready_d;
            tr_q    <= tr_d;
            trv_q   <= trv_d;
            v1_q    <= v1_d;
            pv_q    <= pv_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vector_pe_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .MULT_PIPE (MULT_PIPE)
        ) u_lane (
            .clk      (CLK),
            .rst      (ASYNC_RST),
            .sync_rst (SYNC_RST),
            .en       (EN),
            .load     (WeightLoad),
            .swap     (swap_fire),
            .in_valid (InValid),
            .s1_valid (v1_q),
            .weight_in(WeightIn[i*DATA_WIDTH +: DATA_WIDTH]),
            .act_in   (Input[i*DATA_WIDTH +: DATA_WIDTH]),
            .psum_in  (PsumIn[i*ACC_WIDTH +: ACC_WIDTH]),
            .psum_out (PsumOut[i*ACC_WIDTH +: ACC_WIDTH]),
            .ovf      (Overflow[i])
        );
    end

    assign WeightReady  = ready_q;
    assign ToRight      = tr_q;
    assign ToRightValid = trv_q;
    assign PsumValid    = pv_q;
endmodule

// File: tb/tb_vector_processing_element.sv
// tb_vector_processing_element: directed scoreboard bench for the vector PE (default build and VECTOR_PE_SATURATE_EN build)
module tb_vector_processing_element;
    localparam int L  = 4;
    localparam int DW = 8;
    localparam int AW = 32;

    logic            CLK = 1'b0;
    logic            ASYNC_RST, SYNC_RST, EN, InValid, WeightLoad, WeightSwap;
    logic [L*DW-1:0] Input, WeightIn, ToRight;
    logic [L*AW-1:0] PsumIn, PsumOut;
    logic            WeightReady, ToRightValid, PsumValid;
    logic [L-1:0]    Overflow;

    int           errors = 0;
    int           checks = 0;
    logic [127:0] q[$];
    int           m_active[4];
    int           m_shadow[4];
    bit           m_ready;
    logic [3:0]   m_ovf;
    logic         adv = 1'b0;

    vector_processing_element #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .LANES(L), .MULT_PIPE(1)
    ) dut (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN),
        .InValid(InValid), .Input(Input), .PsumIn(PsumIn),
        .WeightLoad(WeightLoad), .WeightIn(WeightIn), .WeightSwap(WeightSwap),
        .WeightReady(WeightReady), .ToRight(ToRight), .ToRightValid(ToRightValid),
        .PsumOut(PsumOut), .PsumValid(PsumValid), .Overflow(Overflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack8(input int a0, input int a1, input int a2, input int a3);
        return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    function automatic logic [127:0] pack32(input int a0, input int a1, input int a2, input int a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [31:0] mac(input int a, input int w, input int p, output bit ov);
        longint s;
        s  = longint'(a) * longint'(w) + longint'(p);
        ov = 1'b0;
`ifdef VECTOR_PE_SATURATE_EN
        if (s > 64'sd2147483647) begin
            ov = 1'b1;
            return 32'h7fff_ffff;
        end
        if (s < -64'sd2147483648) begin
            ov = 1'b1;
            return 32'h8000_0000;
        end
`endif
        return s[31:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_active[i] = 0;
            m_shadow[i] = 0;
        end
        m_ready = 1'b0;
        m_ovf   = '0;
        q.delete();
    endtask

    task automatic step(input bit en, input bit ld, input logic [31:0] w, input bit sw,
                        input bit v, input logic [31:0] act, input logic [127:0] ps);
        logic [127:0] e;
        bit           ov;
        EN = en; WeightLoad = ld; WeightIn = w; WeightSwap = sw;
        InValid = v; Input = act; PsumIn = ps;
        if (en) begin
            if (v) begin
                for (int i = 0; i < 4; i++) begin
                    e[32*i +: 32] = mac(int'($signed(act[8*i +: 8])), m_active[i], int'($signed(ps[32*i +: 32])), ov);
                    m_ovf[i] = m_ovf[i] | ov;
                end
                q.push_back(e);
            end
            if (sw && m_ready) for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
            if (ld) for (int i = 0; i < 4; i++) m_shadow[i] = int'($signed(w[8*i +: 8]));
            m_ready = ld ? 1'b1 : (sw ? 1'b0 : m_ready);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_psum"}, PsumOut, '0);
        chk({tag, "_psum_valid"}, PsumValid, '0);
        chk({tag, "_to_right"}, ToRight, '0);
        chk({tag, "_to_right_valid"}, ToRightValid, '0);
        chk({tag, "_weight_ready"}, WeightReady, '0);
        chk({tag, "_overflow"}, Overflow, '0);
    endtask

    always @(posedge CLK) adv <= EN & ~SYNC_RST & ~ASYNC_RST;

    always @(negedge CLK) begin
        if (adv && PsumValid) begin
            if (q.size() == 0) chk("unexpected_psum_valid", PsumValid, 1'b0);
            else chk("psum_out", PsumOut, q.pop_front());
        end
    end

    initial begin
        ASYNC_RST = 1'b1; SYNC_RST = 1'b0; EN = 1'b1; InValid = 1'b1;
        WeightLoad = 1'b1; WeightSwap = 1'b1; Input = 32'h1122_3344;
        WeightIn = 32'h5566_7788; PsumIn = {4{32'h0bad_f00d}};
        repeat (3) @(posedge CLK);
        #1;
        check_idle("reset");
        model_reset();
        ASYNC_RST = 1'b0;

        step(1, 1, pack8(3, -2, 1, 0), 0, 0, '0, '0);
        chk("load_ready", WeightReady, m_ready);
        step(1, 0, '0, 1, 0, '0, '0);
        chk("swap_ready", WeightReady, m_ready);
        step(1, 0, '0, 0, 1, pack8(-5, 4, 7, 9), pack32(100, -1, 0, 5));
        chk("tr_valid", ToRightValid, 1'b1);
        chk("tr_data", ToRight, pack8(-5, 4, 7, 9));
        chk("lat1_valid", PsumValid, 1'b0);
        idle();
        chk("lat2_valid", PsumValid, 1'b1);
        chk("tr_valid_drop", ToRightValid, 1'b0);
        chk("tr_hold", ToRight, pack8(-5, 4, 7, 9));
        idle();

        step(1, 1, pack8(2, 2, 2, 2), 0, 0, '0, '0);
        step(1, 0, '0, 1, 0, '0, '0);
        step(1, 1, pack8(7, 7, 7, 7), 0, 0, '0, '0);
        chk("shadow_ready", WeightReady, m_ready);
        step(1, 0, '0, 1, 1, pack8(10, 10, 10, 10), '0);
        step(1, 0, '0, 0, 1, pack8(10, 10, 10, 10), '0);
        chk("swap_beat_ready", WeightReady, m_ready);
        idle();
        idle();

        step(1, 0, '0, 1, 0, '0, '0);
        step(1, 0, '0, 0, 1, pack8(1, 1, 1, 1), '0);
        chk("noload_swap_ready", WeightReady, m_ready);
        step(1, 1, pack8(5, 5, 5, 5), 0, 0, '0, '0);
        step(1, 1, pack8(9, 9, 9, 9), 1, 0, '0, '0);
        chk("load_swap_ready", WeightReady, m_ready);
        step(1, 0, '0, 0, 1, pack8(1, 1, 1, 1), '0);
        step(1, 0, '0, 1, 0, '0, '0);
        step(1, 0, '0, 0, 1, pack8(1, 1, 1, 1), '0);
        idle();
        idle();

        step(1, 0, '0, 0, 1, pack8(3, 3, 3, 3), pack32(1, 1, 1, 1));
        for (int c = 0; c < 3; c++) begin
            step(0, 1, pack8(-1, -1, -1, -1), 1, 1, pack8(77, 77, 77, 77), {4{32'h1234_5678}});
            chk("stall_valid", PsumValid, 1'b0);
            chk("stall_ready", WeightReady, m_ready);
            chk("stall_tr", ToRight, pack8(3, 3, 3, 3));
        end
        idle();
        chk("stall_resume_valid", PsumValid, 1'b1);
        idle();

        step(1, 1, pack8(127, -128, 1, 0), 0, 0, '0, '0);
        step(1, 0, '0, 1, 0, '0, '0);
        step(1, 0, '0, 0, 1, pack8(127, 127, 5, 0), pack32(2147483638, -2147483643, 3, 0));
        idle();
        idle();
        chk("overflow_flag", Overflow, m_ovf);
        step(1, 0, '0, 0, 1, pack8(0, 0, 0, 0), pack32(4, 4, 4, 4));
        idle();
        idle();
        chk("overflow_sticky", Overflow, m_ovf);

        step(1, 1, pack8(6, 6, 6, 6), 0, 0, '0, '0);
        SYNC_RST = 1'b1; EN = 1'b0; InValid = 1'b1;
        @(posedge CLK);
        #1;
        check_idle("sync_rst");
        SYNC_RST = 1'b0;
        model_reset();

        step(1, 1, pack8(4, 4, 4, 4), 0, 0, '0, '0);
        step(1, 0, '0, 1, 0, '0, '0);
        step(1, 0, '0, 0, 1, pack8(2, 3, 4, 5), pack32(9, 9, 9, 9));
        step(1, 0, '0, 0, 1, pack8(6, 7, 8, 9), pack32(1, 2, 3, 4));
        #2;
        ASYNC_RST = 1'b1;
        #1;
        check_idle("async_rst");
        model_reset();
        @(posedge CLK);
        #1;
        ASYNC_RST = 1'b0;
        idle();
        chk("flushed_valid", PsumValid, 1'b0);
        step(1, 0, '0, 0, 1, pack8(5, 5, 5, 5), pack32(7, 7, 7, 7));
        idle();
        idle();
        chk("drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
